imem_loadable: RTL and testbench
================================

// Module: imem_loadable
// PURPOSE
//  Parametrised instruction memory for the SimpleARM core. Replaces the fixed
//  combinational ROM: the program is loaded at run time through a load port, and
//  fetches are registered with a valid/ready handshake. Out-of-range and
//  misaligned fetches return a safe fault word instead of X.
//  Sits between the fetch stage (PC) and the bench/boot loader.
// PARAMETERS
//  DATA_WIDTH   32            instruction word width
//  ADDR_WIDTH   32            fetch byte-address width
//  DEPTH        64            number of words; index = fetch_addr[ADDR_WIDTH-1:2]
//  AUTOINC      1             1: load address = internal pointer; 0: load_addr used
//  FAULT_WORD   32'hEAFFFFFE  returned on fault (B . , branch-to-self)
// PORTS
//  clk          in   1            clock, all state on rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  load_en      in   1            write load_data this cycle
//  load_addr    in   $clog2(DEPTH) word index (ignored when AUTOINC=1)
//  load_data    in   DATA_WIDTH   word to write
//  load_done    in   1            end of program load
//  load_ovf     out  1            sticky: auto-inc write dropped past DEPTH-1
//  load_count   out  $clog2(DEPTH)+1  words written in current/last load
//  fetch_req    in   1            fetch request
//  fetch_addr   in   ADDR_WIDTH   byte address (PC)
//  fetch_ready  out  1            request accepted this cycle when high
//  fetch_valid  out  1            fetch_rdata/fetch_fault valid
//  fetch_rdata  out  DATA_WIDTH   instruction word
//  fetch_fault  out  1            misaligned (addr[1:0]!=0) or index >= DEPTH
// BEHAVIOUR
//  Reset: state=EMPTY; fetch_valid=0, fetch_fault=0, fetch_rdata=0, load_ovf=0,
//   load_count=0, load pointer=0. Memory array is NOT cleared.
//  FSM: EMPTY -load_en-> LOAD; LOAD -load_done-> RUN; RUN -load_en-> LOAD;
//   EMPTY -load_done-> RUN (empty program allowed). Entering LOAD clears
//   load_count, pointer and load_ovf; the entering load_en write is performed.
//  Load write (LOAD, or the entering cycle): AUTOINC=1 writes mem[ptr], ptr++;
//   if ptr==DEPTH the write is dropped and load_ovf sets (sticky). AUTOINC=0
//   writes mem[load_addr]; load_addr>=DEPTH dropped and sets load_ovf.
//   load_count increments on each performed write, saturating at DEPTH.
//  load_en and load_done same cycle: write performed, then go to RUN.
//  fetch_ready = (state==RUN) && !load_en (combinational).
//  Accept = fetch_req && fetch_ready. One-cycle latency: on the edge after
//   accept, fetch_valid=1 with rdata=mem[idx] or FAULT_WORD+fetch_fault=1.
//   No accept -> fetch_valid=0 next cycle; rdata holds last value.
//  A fetch accepted in the cycle before a reload still completes normally.
//  Read-during-write to same word cannot occur (ready low while load_en).
//  Back-to-back accepts give one result per cycle (full throughput).
//  Async reset mid-load or mid-fetch: outputs to reset values immediately;
//   already-written words keep contents; fresh load required (EMPTY).
// TESTING
//  1 Reset, AUTOINC=1: load 24 words 0xE3A09000.. then load_done -> load_count=24,
//    load_ovf=0; fetch 0x00,0x14 -> rdata 0xE3A09000, word[5], valid 1 cycle later.
//  2 EMPTY state: fetch_req=1 -> fetch_ready=0, fetch_valid stays 0.
//  3 RUN: fetch 0x102 -> fault=1, rdata=0xEAFFFFFE; fetch 0x100 (DEPTH=64) -> fault.
//  4 DEPTH=4 AUTOINC=1: 5 load writes -> load_count=4, load_ovf=1, word0 intact.
//  5 Back-to-back fetches 0x0,0x4,0x8 -> valid 3 consecutive cycles, in order;
//    load_en asserted during stream -> ready drops same cycle, prior fetch completes.
//  6 Drop reset_n mid-load -> fetch_valid=0, state EMPTY, load_count=0 at once.

Source files
------------

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with registered, handshaked fetch.
// Out-of-range or misaligned fetches return FAULT_WORD with fetch_fault set.
module imem_loadable #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int AUTOINC    = 1,
   parameter logic [DATA_WIDTH-1:0] FAULT_WORD = 32'hEAFFFFFE
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      load_en,
   input  logic [$clog2(DEPTH)-1:0]  load_addr,
   input  logic [DATA_WIDTH-1:0]     load_data,
   input  logic                      load_done,
   output logic                      load_ovf,
   output logic [$clog2(DEPTH):0]    load_count,
   input  logic                      fetch_req,
   input  logic [ADDR_WIDTH-1:0]     fetch_addr,
   output logic                      fetch_ready,
   output logic                      fetch_valid,
   output logic [DATA_WIDTH-1:0]     fetch_rdata,
   output logic                      fetch_fault
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
   state_t state, state_nx;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0] ptr, ptr_nx, count_nx, base_ptr, base_cnt, wr_idx;
   logic entering, wr_ok, ovf_nx, accept, f_fault;
   logic [ADDR_WIDTH-3:0] f_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   // A load_en outside LOAD starts a fresh program: counters restart before this write.
   always_comb begin
      entering = load_en && state != LOAD;
      base_ptr = entering ? '0 : ptr;
      base_cnt = entering ? '0 : load_count;
      wr_idx   = AUTOINC != 0 ? base_ptr : {1'b0, load_addr};
      wr_ok    = load_en && wr_idx < CW'(DEPTH);
      ptr_nx   = (wr_ok && AUTOINC != 0) ? base_ptr + 1'b1 : base_ptr;
      count_nx = (wr_ok && base_cnt < CW'(DEPTH)) ? base_cnt + 1'b1 : base_cnt;
      ovf_nx   = (load_en && !wr_ok) || (!entering && load_ovf);
      state_nx = load_done ? RUN : load_en ? LOAD : state;
   end

   always_comb begin
      f_idx       = fetch_addr[ADDR_WIDTH-1:2];
      f_fault     = (fetch_addr[1:0] != 2'b00) || f_idx >= (ADDR_WIDTH-2)'(DEPTH);
      rd_word     = mem[f_idx[IW-1:0]];
      fetch_ready = state == RUN && !load_en;
      accept      = fetch_req && fetch_ready;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= EMPTY;
         ptr         <= '0;
         load_count  <= '0;
         load_ovf    <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_fault <= 1'b0;
         fetch_rdata <= '0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         load_count  <= count_nx;
         load_ovf    <= ovf_nx;
         fetch_valid <= accept;
         if (accept) begin
            fetch_rdata <= f_fault ? FAULT_WORD : rd_word;
            fetch_fault <= f_fault;
         end
      end
   end

   // Array has no reset so loaded words survive a reset.
   always_ff @(posedge clk) begin
      if (reset_n && wr_ok) mem[wr_idx[IW-1:0]] <= load_data;
   end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: three differently parameterised memories share one random stimulus
// stream and are each checked against a behavioural model of the load/fetch rules.
module tb_imem_loadable;
   localparam int N = 3;
   localparam int D[N]  = '{64, 4, 6};
   localparam int AU[N] = '{1, 1, 0};
   localparam int LW[N] = '{6, 2, 3};
   localparam logic [31:0] FW = 32'hEAFFFFFE;
   localparam int M_EMPTY = 0, M_LOAD = 1, M_RUN = 2;

   logic clk = 0, reset_n = 1, load_en = 0, load_done = 0, fetch_req = 0;
   logic [5:0] la = '0;
   logic [31:0] ld = '0, fa = '0;
   logic o_ready[N], o_valid[N], o_fault[N], o_ovf[N];
   logic [31:0] o_rdata[N], o_cnt[N];
   logic [6:0] a_cnt;
   logic [2:0] b_cnt;
   logic [3:0] c_cnt;

   assign o_cnt[0] = 32'(a_cnt);
   assign o_cnt[1] = 32'(b_cnt);
   assign o_cnt[2] = 32'(c_cnt);

   always #5 clk = ~clk;

   imem_loadable #(.DEPTH(64), .AUTOINC(1)) u_a (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(la), .load_data(ld),
      .load_done(load_done), .load_ovf(o_ovf[0]), .load_count(a_cnt), .fetch_req(fetch_req),
      .fetch_addr(fa), .fetch_ready(o_ready[0]), .fetch_valid(o_valid[0]),
      .fetch_rdata(o_rdata[0]), .fetch_fault(o_fault[0]));

   imem_loadable #(.DEPTH(4), .AUTOINC(1)) u_b (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(la[1:0]), .load_data(ld),
      .load_done(load_done), .load_ovf(o_ovf[1]), .load_count(b_cnt), .fetch_req(fetch_req),
      .fetch_addr(fa), .fetch_ready(o_ready[1]), .fetch_valid(o_valid[1]),
      .fetch_rdata(o_rdata[1]), .fetch_fault(o_fault[1]));

   imem_loadable #(.DEPTH(6), .AUTOINC(0)) u_c (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(la[2:0]), .load_data(ld),
      .load_done(load_done), .load_ovf(o_ovf[2]), .load_count(c_cnt), .fetch_req(fetch_req),
      .fetch_addr(fa), .fetch_ready(o_ready[2]), .fetch_valid(o_valid[2]),
      .fetch_rdata(o_rdata[2]), .fetch_fault(o_fault[2]));

   logic [31:0] mm [N][64];
   bit kn [N][64];
   int mode[N], ptr[N], cnt[N];
   bit ovf[N], ev[N], ef[N], ek[N];
   logic [31:0] er[N];
   int vecs = 0, errs = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mode[k] = M_EMPTY; ptr[k] = 0; cnt[k] = 0; ovf[k] = 0;
         ev[k] = 0; ef[k] = 0; er[k] = '0; ek[k] = 1;
      end
   endtask

   task automatic model_step(int k);
      int a;
      int unsigned idx;
      bit f;
      if (fetch_req && mode[k] == M_RUN && !load_en) begin
         idx = fa >> 2;
         f = (fa[1:0] != 2'b00) || idx >= D[k];
         ev[k] = 1; ef[k] = f;
         ek[k] = f || kn[k][idx];
         er[k] = f ? FW : mm[k][idx];
      end else ev[k] = 0;
      if (load_en) begin
         if (mode[k] != M_LOAD) begin ptr[k] = 0; cnt[k] = 0; ovf[k] = 0; end
         a = AU[k] != 0 ? ptr[k] : int'(la) % (1 << LW[k]);
         if (a < D[k]) begin
            mm[k][a] = ld; kn[k][a] = 1;
            if (cnt[k] < D[k]) cnt[k]++;
            if (AU[k] != 0) ptr[k]++;
         end else ovf[k] = 1;
      end
      if (load_done) mode[k] = M_RUN;
      else if (load_en) mode[k] = M_LOAD;
   endtask

   task automatic check_outs();
      for (int k = 0; k < N; k++) begin
         chk($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(ev[k]));
         chk($sformatf("fault%0d", k), 32'(o_fault[k]), 32'(ef[k]));
         if (ek[k]) chk($sformatf("rdata%0d", k), o_rdata[k], er[k]);
         chk($sformatf("count%0d", k), o_cnt[k], 32'(cnt[k]));
         chk($sformatf("ovf%0d", k), 32'(o_ovf[k]), 32'(ovf[k]));
      end
   endtask

   task automatic cycle();
      #1;
      for (int k = 0; k < N; k++)
         chk($sformatf("ready%0d", k), 32'(o_ready[k]), 32'(mode[k] == M_RUN && !load_en));
      for (int k = 0; k < N; k++) model_step(k);
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic async_reset();
      #2;
      reset_n = 0;
      #1;
      model_reset();
      check_outs();
      for (int k = 0; k < N; k++) chk($sformatf("rst_ready%0d", k), 32'(o_ready[k]), 32'd0);
      @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      async_reset();
      fetch_req = 1; fa = '0;
      repeat (3) cycle();
      fetch_req = 0;
      for (int i = 0; i < 24; i++) begin
         load_en = 1; ld = 32'hE3A09000 + 32'(i); la = 6'(i);
         cycle();
      end
      load_en = 0; load_done = 1;
      cycle();
      load_done = 0;
      chk("cnt24", o_cnt[0], 32'd24);
      chk("ovf24", 32'(o_ovf[0]), 32'd0);
      chk("small_cnt", o_cnt[1], 32'd4);
      chk("small_ovf", 32'(o_ovf[1]), 32'd1);
      fetch_req = 1; fa = 32'h0;
      cycle();
      chk("word0", o_rdata[0], 32'hE3A09000);
      chk("small_word0", o_rdata[1], 32'hE3A09000);
      fa = 32'h14;
      cycle();
      chk("word5", o_rdata[0], 32'hE3A09005);
      fa = 32'h102;
      cycle();
      chk("mis_fault", 32'(o_fault[0]), 32'd1);
      chk("mis_rdata", o_rdata[0], FW);
      fa = 32'h100;
      cycle();
      chk("oor_fault", 32'(o_fault[0]), 32'd1);
      for (int i = 0; i < 3; i++) begin
         fa = 32'(i * 4);
         cycle();
         chk("b2b_valid", 32'(o_valid[0]), 32'd1);
         chk("b2b_rdata", o_rdata[0], 32'hE3A09000 + 32'(i));
      end
      load_en = 1; ld = 32'h12345678; la = '0;
      #1;
      chk("ready_drop", 32'(o_ready[0]), 32'd0);
      cycle();
      chk("prior_done", 32'(o_valid[0]), 32'd0);
      load_en = 0; load_done = 1;
      cycle();
      load_done = 0;
      repeat (3000) begin
         if ($urandom_range(0, 499) == 0) async_reset();
         else begin
            load_en   = $urandom_range(0, 9) == 0;
            load_done = $urandom_range(0, 19) == 0;
            ld        = $urandom;
            la        = 6'($urandom);
            fetch_req = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 7))
               6: fa = 32'($urandom_range(0, 300));
               7: fa = $urandom;
               default: fa = 32'($urandom_range(0, 70)) << 2;
            endcase
            cycle();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
